// File: rtl/array_serializer.sv
`default_nettype none
// ============================================================================
// Module      : array_serializer
// Description : Transmit end of a two-wire (data + start) serial link. Holds a
//               DEPTH x WIDTH word buffer loaded through a write port and, on a
//               send request, streams every word back-to-back LSB-first on
//               serial_out with a one-cycle start marker on the first bit.
// Revision    : 1.0 - initial release
// ============================================================================
module array_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             send,
    output logic             busy,
    output logic             done,
    output logic             serial_out,
    output logic             start
);

    // Bit counter width; a 1-bit counter is kept even for WIDTH=1.
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0]    c_st_idle   = 1'b0;
    localparam logic [0:0]    c_st_shift  = 1'b1;
    localparam logic [BW-1:0] c_last_bit  = BW'(WIDTH - 1);
    localparam logic [AW-1:0] c_last_word = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_depth     = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State, datapath and registered outputs
    // ------------------------------------------------------------------
    logic [0:0]       state_q,      state_d;
    logic [BW-1:0]    bit_cnt_q,    bit_cnt_d;
    logic [AW-1:0]    word_cnt_q,   word_cnt_d;
    logic [WIDTH-1:0] shift_q,      shift_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             serial_out_q, serial_out_d;
    logic             start_q,      start_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;

    // Helper combinational wires
    logic             w_idle;
    logic             w_wr_ok;
    logic             w_accept;
    logic             w_bit_last;
    logic             w_word_last;
    logic [AW-1:0]    w_next_idx;
    logic [WIDTH-1:0] w_next_word;
    logic [WIDTH-1:0] w_word0;
    logic [WIDTH-1:0] w_shift_nxt;

    // Write qualification, frame acceptance and next-word fetch
    always_comb begin
        w_idle      = (state_q == c_st_idle);
        // Writes are only honoured while idle so a frame in flight is never
        // corrupted; out-of-range addresses are silently dropped.
        w_wr_ok     = wr_en && w_idle && ({1'b0, wr_addr} < c_depth);
        w_accept    = send && w_idle;
        w_bit_last  = (bit_cnt_q == c_last_bit);
        w_word_last = (word_cnt_q == c_last_word);
        // Index of the word that follows the current one; wraps to 0 on the
        // last word so the mux below never addresses past the buffer.
        w_next_idx  = w_word_last ? '0 : (word_cnt_q + AW'(1));
        w_next_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_next_idx == AW'(i)) begin
                w_next_word = mem_q[i];
            end
        end
        // A write to word 0 on the same edge as the send must be what goes
        // out first, so it bypasses the buffer straight into the shifter.
        w_word0     = (w_wr_ok && (wr_addr == '0)) ? wr_data : mem_q[0];
        w_shift_nxt = shift_q >> 1;
    end

    // Buffer update from the write port
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (w_wr_ok && (wr_addr == AW'(i))) begin
                mem_d[i] = wr_data;
            end
        end
    end

    // Next-state logic: IDLE -> SHIFT on accepted send, back after last bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (w_accept) begin
                    state_d = c_st_shift;
                end
            end
            c_st_shift: begin
                if (w_bit_last && w_word_last) begin
                    state_d = c_st_idle;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // Datapath and output decode; every output is computed one cycle ahead
    // and registered so no input reaches a pin combinationally.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        shift_d      = shift_q;
        serial_out_d = 1'b0;
        start_d      = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (w_accept) begin
                    shift_d      = w_word0;
                    bit_cnt_d    = '0;
                    word_cnt_d   = '0;
                    serial_out_d = w_word0[0];
                    start_d      = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            c_st_shift: begin
                if (w_bit_last) begin
                    bit_cnt_d = '0;
                    if (w_word_last) begin
                        // Frame complete: one-cycle done, line returns low.
                        word_cnt_d = '0;
                        shift_d    = '0;
                        done_d     = 1'b1;
                    end else begin
                        // Next word loads on the edge ending the current
                        // word's last bit, so words are contiguous.
                        word_cnt_d   = w_next_idx;
                        shift_d      = w_next_word;
                        serial_out_d = w_next_word[0];
                        busy_d       = 1'b1;
                    end
                end else begin
                    bit_cnt_d    = bit_cnt_q + BW'(1);
                    shift_d      = w_shift_nxt;
                    serial_out_d = w_shift_nxt[0];
                    busy_d       = 1'b1;
                end
            end
            default: begin
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                shift_d    = '0;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any frame at once
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_st_idle;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            shift_q      <= '0;
            serial_out_q <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shift_q      <= shift_d;
            serial_out_q <= serial_out_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign serial_out = serial_out_q;
    assign start      = start_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
`default_nettype wire
